// File: rtl/transport_tx_arbiter.sv
// Arbitrates control and audio words onto a single packet sender, counts completed
// packets and paces sendData drain requests with a minimum gap.
module transport_tx_arbiter #(
    parameter int MAX_CTRL_BURST      = 4,
    parameter int AUDIO_WORDS_PER_PKT = 7,
    parameter int SEND_GAP            = 64,
    parameter int BUSY_TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ctrl_req,
    input  logic [15:0] ctrl_data,
    output logic        ctrl_ack,
    input  logic        audio_req,
    input  logic [15:0] audio_data,
    output logic        audio_ack,
    output logic [1:0]  cmd,
    output logic [15:0] data,
    input  logic        busy,
    input  logic        sending,
    output logic        sendData,
    output logic        timeout_err,
    output logic        pend_ovf
);

    localparam int STREAK_W = $clog2(MAX_CTRL_BURST + 1);
    localparam int AUDIO_W  = $clog2(AUDIO_WORDS_PER_PKT + 1);
    localparam int GAP_W    = $clog2(SEND_GAP + 1);
    localparam int WAIT_W   = $clog2(BUSY_TIMEOUT + 1);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_CTRL_BURST);
    localparam logic [AUDIO_W-1:0]  AUDIO_LAST = AUDIO_W'(AUDIO_WORDS_PER_PKT - 1);
    localparam logic [GAP_W-1:0]    GAP_LOAD   = GAP_W'(SEND_GAP);
    localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(BUSY_TIMEOUT - 1);

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_CTRL  = 2'b01;
    localparam logic [1:0] CMD_AUDIO = 2'b10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } arbState_t;

    arbState_t            state;
    logic [STREAK_W-1:0]  ctrlStreak;
    logic [AUDIO_W-1:0]   audioCnt;
    logic [3:0]           pendCnt;
    logic [GAP_W-1:0]     gapCnt;
    logic [WAIT_W-1:0]    waitCnt;
    logic                 grantAudio;

    logic ctrlWins;
    logic txnDone;
    logic ctrlDone;
    logic audioDone;
    logic audioWrap;
    logic pktInc;
    logic sendFire;

    // Audio only pre-empts control once control has used up its burst allowance.
    assign ctrlWins  = ctrl_req && !(audio_req && (ctrlStreak == STREAK_MAX));

    assign txnDone   = (state == WAIT_DONE) && !busy;
    assign ctrlDone  = txnDone && !grantAudio;
    assign audioDone = txnDone && grantAudio;
    assign audioWrap = audioDone && (audioCnt == AUDIO_LAST);
    assign pktInc    = ctrlDone || audioWrap;
    assign sendFire  = (pendCnt != 4'd0) && !sending && (gapCnt == '0) && !sendData;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cmd         <= CMD_IDLE;
            data        <= 16'h0000;
            ctrl_ack    <= 1'b0;
            audio_ack   <= 1'b0;
            timeout_err <= 1'b0;
            ctrlStreak  <= '0;
            waitCnt     <= '0;
            grantAudio  <= 1'b0;
        end else begin
            ctrl_ack    <= 1'b0;
            audio_ack   <= 1'b0;
            timeout_err <= 1'b0;
            cmd         <= CMD_IDLE;
            case (state)
                IDLE: begin
                    if (ctrl_req || audio_req) begin
                        state      <= ISSUE;
                        grantAudio <= !ctrlWins;
                        if (ctrlWins) begin
                            ctrl_ack <= 1'b1;
                            data     <= ctrl_data;
                            cmd      <= CMD_CTRL;
                            if (ctrlStreak != STREAK_MAX) begin
                                ctrlStreak <= ctrlStreak + STREAK_W'(1);
                            end
                        end else begin
                            audio_ack  <= 1'b1;
                            data       <= audio_data;
                            cmd        <= CMD_AUDIO;
                            ctrlStreak <= '0;
                        end
                    end
                end
                ISSUE: begin
                    state   <= WAIT_BUSY;
                    waitCnt <= '0;
                end
                WAIT_BUSY: begin
                    if (busy) begin
                        state <= WAIT_DONE;
                    end else if (waitCnt == WAIT_LAST) begin
                        // Sender never picked the word up; drop it without accounting.
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Packet accounting and drain pacing run alongside the arbiter every cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            audioCnt <= '0;
            pendCnt  <= 4'd0;
            pend_ovf <= 1'b0;
            gapCnt   <= '0;
            sendData <= 1'b0;
        end else begin
            if (audioDone) begin
                audioCnt <= audioWrap ? '0 : audioCnt + AUDIO_W'(1);
            end

            sendData <= sendFire;
            if (sendFire) begin
                gapCnt <= GAP_LOAD;
            end else if (gapCnt != '0) begin
                gapCnt <= gapCnt - GAP_W'(1);
            end

            if (pktInc && !sendFire) begin
                if (pendCnt == 4'd15) begin
                    pend_ovf <= 1'b1;
                end else begin
                    pendCnt <= pendCnt + 4'd1;
                end
            end else if (sendFire && !pktInc) begin
                pendCnt <= pendCnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_transport_tx_arbiter.sv
// Self-checking bench for transport_tx_arbiter: vector table, directed corner cases
// and a randomized run against a transaction-level reference model.
module tb_transport_tx_arbiter;

    localparam int MAXB = 4;
    localparam int WPP  = 7;
    localparam int GAP  = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrl_req;
    logic [15:0] ctrl_data;
    logic        ctrl_ack;
    logic        audio_req;
    logic [15:0] audio_data;
    logic        audio_ack;
    logic [1:0]  cmd;
    logic [15:0] data;
    logic        busy;
    logic        sending;
    logic        sendData;
    logic        timeout_err;
    logic        pend_ovf;

    always #5 clk = ~clk;

    transport_tx_arbiter #(
        .MAX_CTRL_BURST(4),
        .AUDIO_WORDS_PER_PKT(7),
        .SEND_GAP(64),
        .BUSY_TIMEOUT(255)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ctrl_req(ctrl_req),
        .ctrl_data(ctrl_data),
        .ctrl_ack(ctrl_ack),
        .audio_req(audio_req),
        .audio_data(audio_data),
        .audio_ack(audio_ack),
        .cmd(cmd),
        .data(data),
        .busy(busy),
        .sending(sending),
        .sendData(sendData),
        .timeout_err(timeout_err),
        .pend_ovf(pend_ovf)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // sender model
    bit senderOn, randBusy, doneFlag, prevDone;
    int cfgDelay, cfgLen, sPhase, sCnt, sLen;

    // requester / environment randomisation
    bit randReq, randSend;

    // reference model
    bit modelOn, mIdlePrev, mOvf, curAudio;
    int mStreak, mAudio, mPend, lastSend;

    typedef struct {
        bit          cReq;
        bit          aReq;
        logic [15:0] cData;
        logic [15:0] aData;
        int          expWin;   // 1 = control, 2 = audio
        int          busyLen;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: inputs set before the call are seen at the next rising edge,
    // outputs are sampled on the following falling edge.
    task automatic step();
        bit capC, capA, capSend, grant, winC, winA, inc, expSend, idleNow;
        logic [15:0] capCD, capAD;
        capC = ctrl_req; capA = audio_req; capSend = sending;
        capCD = ctrl_data; capAD = audio_data;
        @(negedge clk);
        cyc++;
        if (modelOn) begin
            grant = mIdlePrev && (capC || capA);
            winC  = grant && capC && !(capA && mStreak == MAXB);
            winA  = grant && !winC;
            check("ctrl_ack", ctrl_ack, winC);
            check("audio_ack", audio_ack, winA);
            if (grant) begin
                check("cmd_grant", cmd, winC ? 2'b01 : 2'b10);
                check("data_grant", data, winC ? capCD : capAD);
                mStreak  = winC ? ((mStreak == MAXB) ? MAXB : mStreak + 1) : 0;
                curAudio = winA;
                $display("txn @%0d: grant %s data=%h", cyc, winC ? "ctrl" : "audio", data);
            end else begin
                check("cmd_idle", cmd, 2'b00);
            end
            idleNow   = prevDone || (mIdlePrev && !grant);
            mIdlePrev = idleNow;

            inc = 1'b0;
            if (prevDone) begin
                if (curAudio) begin
                    mAudio++;
                    if (mAudio == WPP) begin
                        mAudio = 0;
                        inc = 1'b1;
                    end
                end else begin
                    inc = 1'b1;
                end
            end
            expSend = (mPend > 0) && !capSend && (cyc - lastSend >= GAP + 1);
            check("sendData", sendData, expSend);
            if (expSend) lastSend = cyc;
            if (inc && !expSend) begin
                if (mPend == 15) mOvf = 1'b1;
                else mPend++;
            end else if (expSend && !inc) begin
                mPend--;
            end
            check("pend_ovf", pend_ovf, mOvf);
            check("timeout_err", timeout_err, 1'b0);
        end

        doneFlag = 1'b0;
        case (sPhase)
            0: if (senderOn && cmd != 2'b00) begin
                sCnt   = randBusy ? int'($urandom_range(1, 3)) : cfgDelay;
                sLen   = randBusy ? int'($urandom_range(1, 5)) : cfgLen;
                sPhase = 1;
            end
            1: begin
                sCnt--;
                if (sCnt == 0) begin
                    busy = 1'b1; sPhase = 2; sCnt = sLen;
                end
            end
            default: begin
                sCnt--;
                if (sCnt == 0) begin
                    busy = 1'b0; sPhase = 0; doneFlag = 1'b1;
                end
            end
        endcase

        if (ctrl_ack) ctrl_req = 1'b0;
        if (audio_ack) audio_req = 1'b0;
        if (randReq) begin
            if (!ctrl_req && $urandom_range(0, 3) == 0) begin
                ctrl_req = 1'b1; ctrl_data = 16'($urandom);
            end
            if (!audio_req && $urandom_range(0, 3) == 0) begin
                audio_req = 1'b1; audio_data = 16'($urandom);
            end
        end
        if (randSend) sending = ($urandom_range(0, 2) == 0);
        prevDone = doneFlag;
    endtask

    task automatic resetDut();
        modelOn = 1'b0;
        reset = 1'b1;
        ctrl_req = 1'b0; audio_req = 1'b0; busy = 1'b0; sending = 1'b0;
        randReq = 1'b0; randSend = 1'b0; randBusy = 1'b0; senderOn = 1'b1;
        cfgDelay = 2; cfgLen = 3; sPhase = 0;
        step();
        step();
        reset = 1'b0;
        mStreak = 0; mAudio = 0; mPend = 0; mOvf = 1'b0; curAudio = 1'b0;
        lastSend = -1000; prevDone = 1'b0; doneFlag = 1'b0; mIdlePrev = 1'b1;
        modelOn = 1'b1;
    endtask

    // Raise one request, run it to completion, then one more cycle for accounting.
    task automatic runTxn(input bit isAudio, input logic [15:0] word, input string name);
        bit fin;
        fin = 1'b0;
        if (isAudio) begin audio_req = 1'b1; audio_data = word; end
        else begin ctrl_req = 1'b1; ctrl_data = word; end
        for (int i = 0; i < 80 && !fin; i++) begin
            step();
            fin = doneFlag;
        end
        check({name, "_done"}, fin, 1'b1);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int order[10];
        bit got, fin;
        logic [15:0] expData;
        int n, pulses;
        int pulseAt[3];

        ctrl_data = 16'h0; audio_data = 16'h0;
        order = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
        vecs[0]  = '{1'b1, 1'b0, 16'hA55A, 16'h0000, 1, 16};
        vecs[1]  = '{1'b0, 1'b1, 16'h0000, 16'h1234, 2, 3};
        for (int i = 0; i < 10; i++) begin
            vecs[2 + i] = '{1'b1, 1'b1, 16'(16'h1000 + i), 16'(16'h2000 + i), order[i], 3};
        end
        vecs[12] = '{1'b1, 1'b0, 16'h7E7E, 16'h0000, 1, 3};

        // reset state
        resetDut();
        check("rst_cmd", cmd, 2'b00);
        check("rst_data", data, 16'h0000);
        check("rst_ctrl_ack", ctrl_ack, 1'b0);
        check("rst_audio_ack", audio_ack, 1'b0);
        check("rst_sendData", sendData, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
        check("rst_pend_ovf", pend_ovf, 1'b0);

        // vector table: single control, single audio, burst fairness sequence
        for (int r = 0; r < 13; r++) begin
            cfgLen = vecs[r].busyLen;
            if (vecs[r].cReq && !ctrl_req) begin ctrl_req = 1'b1; ctrl_data = vecs[r].cData; end
            if (vecs[r].aReq && !audio_req) begin audio_req = 1'b1; audio_data = vecs[r].aData; end
            expData = (vecs[r].expWin == 1) ? ctrl_data : audio_data;
            got = 1'b0;
            for (int k = 0; k < 10 && !got; k++) begin
                step();
                got = ctrl_ack || audio_ack;
            end
            check($sformatf("vec%0d_grant", r), got, 1'b1);
            check($sformatf("vec%0d_winner", r), audio_ack ? 2 : 1, vecs[r].expWin);
            check($sformatf("vec%0d_data", r), data, expData);
            check($sformatf("vec%0d_cmd", r), cmd, (vecs[r].expWin == 1) ? 2'b01 : 2'b10);
            step();
            check($sformatf("vec%0d_cmd_once", r), cmd, 2'b00);
            check($sformatf("vec%0d_ack_once", r), ctrl_ack | audio_ack, 1'b0);
            fin = 1'b0;
            for (int k = 0; k < 60 && !fin; k++) begin
                step();
                fin = doneFlag;
            end
            check($sformatf("vec%0d_done", r), fin, 1'b1);
            if (r == 0) begin
                step();
                check("a55a_pending_1", dut.pendCnt, 4'd1);
                check("a55a_send_lo", sendData, 1'b0);
                step();
                check("a55a_send_hi", sendData, 1'b1);
                check("a55a_pending_0", dut.pendCnt, 4'd0);
                check("a55a_data_hold", data, 16'hA55A);
                step();
                check("a55a_send_once", sendData, 1'b0);
            end else begin
                step();
            end
        end

        // seven audio words make exactly one packet
        resetDut();
        sending = 1'b1;
        for (int i = 0; i < 7; i++) begin
            runTxn(1'b1, 16'($urandom), "audio7");
            check($sformatf("audio7_pend_%0d", i), dut.pendCnt, (i == 6) ? 4'd1 : 4'd0);
        end
        check("audio7_cnt_wrap", dut.audioCnt, 0);

        // drain spacing: three packets queued while sending is held, then released
        resetDut();
        sending = 1'b1; cfgDelay = 1; cfgLen = 1;
        for (int i = 0; i < 3; i++) runTxn(1'b0, 16'(16'hC000 + i), "gapfill");
        check("gap_pending_3", dut.pendCnt, 4'd3);
        sending = 1'b0;
        pulses = 0;
        for (int k = 0; k < 300; k++) begin
            step();
            if (sendData) begin
                if (pulses < 3) pulseAt[pulses] = cyc;
                pulses++;
            end
        end
        check("gap_pulse_count", pulses, 3);
        check("gap_spacing_1", pulseAt[1] - pulseAt[0], 65);
        check("gap_spacing_2", pulseAt[2] - pulseAt[1], 65);
        check("gap_pending_0", dut.pendCnt, 4'd0);

        // busy never arrives
        resetDut();
        modelOn = 1'b0; senderOn = 1'b0;
        ctrl_req = 1'b1; ctrl_data = 16'h0F0F;
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            step();
            got = ctrl_ack;
        end
        check("to_grant", got, 1'b1);
        n = 0; fin = 1'b0;
        for (int k = 0; k < 400 && !fin; k++) begin
            step();
            n++;
            fin = timeout_err;
        end
        check("to_seen", fin, 1'b1);
        check("to_latency", n, 256);
        step();
        check("to_pulse_once", timeout_err, 1'b0);
        check("to_pending", dut.pendCnt, 4'd0);
        senderOn = 1'b1;
        ctrl_req = 1'b1; ctrl_data = 16'h1111;
        step();
        check("to_idle_regrant", ctrl_ack, 1'b1);

        // reset in the middle of a transaction with a saturated pending counter
        resetDut();
        sending = 1'b1; cfgDelay = 1; cfgLen = 1;
        for (int i = 0; i < 16; i++) runTxn(1'b0, 16'(i), "sat");
        check("sat_pending", dut.pendCnt, 4'd15);
        check("sat_ovf", pend_ovf, 1'b1);
        cfgLen = 20;
        ctrl_req = 1'b1; ctrl_data = 16'hBEEF;
        fin = 1'b0;
        for (int k = 0; k < 20 && !fin; k++) begin
            step();
            fin = busy;
        end
        check("mid_busy_reached", fin, 1'b1);
        step();
        step();
        modelOn = 1'b0;
        reset = 1'b1;
        audio_req = 1'b1; audio_data = 16'h5A5A;
        step();
        check("mid_rst_cmd", cmd, 2'b00);
        check("mid_rst_data", data, 16'h0000);
        check("mid_rst_acks", {ctrl_ack, audio_ack}, 2'b00);
        check("mid_rst_send", sendData, 1'b0);
        check("mid_rst_timeout", timeout_err, 1'b0);
        check("mid_rst_ovf", pend_ovf, 1'b0);
        check("mid_rst_pending", dut.pendCnt, 4'd0);
        check("mid_rst_streak", dut.ctrlStreak, 0);
        check("mid_rst_audiocnt", dut.audioCnt, 0);
        check("mid_rst_gap", dut.gapCnt, 0);
        check("mid_rst_wait", dut.waitCnt, 0);
        reset = 1'b0; busy = 1'b0; sPhase = 0;
        step();
        check("held_req_ack", audio_ack, 1'b1);
        check("held_req_data", data, 16'h5A5A);

        // randomized traffic against the reference model
        resetDut();
        randBusy = 1'b1; randReq = 1'b1; randSend = 1'b1;
        for (int k = 0; k < 4000; k++) step();
        randReq = 1'b0; randSend = 1'b0; sending = 1'b0;
        for (int k = 0; k < 1500; k++) step();
        check("rand_final_pending", dut.pendCnt, 4'(mPend));
        check("rand_drained", mPend, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/transport_tx_arbiter.md
TRANSPORT_TX_ARBITER -- requirements
Module: transport_tx_arbiter

Interface
REQ-001 SHALL have parameter MAX_CTRL_BURST, default 4, meaning consecutive control grants allowed while audio waits.
REQ-002 SHALL have parameter AUDIO_WORDS_PER_PKT, default 7, meaning audio words that fill one outgoing packet.
REQ-003 SHALL have parameter SEND_GAP, default 64, meaning minimum clk cycles between sendData pulses.
REQ-004 SHALL have parameter BUSY_TIMEOUT, default 255, meaning max cycles to wait for sender busy after a command.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 ctrl_req  input  1  control requester has a 16-bit word pending; held until ctrl_ack.
REQ-008 ctrl_data  input  16  control word; stable while ctrl_req high.
REQ-009 ctrl_ack  output  1  one-cycle pulse: control word captured.
REQ-010 audio_req  input  1  audio requester has a sample pending; held until audio_ack.
REQ-011 audio_data  input  16  audio sample; stable while audio_req high.
REQ-012 audio_ack  output  1  one-cycle pulse: audio sample captured.
REQ-013 cmd  output  2  to sender: 00 idle, 01 control, 10 audio.
REQ-014 data  output  16  to sender: captured word.
REQ-015 busy  input  1  from sender: word being packetised.
REQ-016 sending  input  1  from sender: packet draining to link.
REQ-017 sendData  output  1  to sender: one-cycle request to drain one packet.
REQ-018 timeout_err  output  1  one-cycle pulse: busy never rose within BUSY_TIMEOUT.
REQ-019 pend_ovf  output  1  sticky: pending-packet counter saturated.

Function
REQ-020 Arbiter FSM SHALL have states IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-021 IDLE: any req high -> latch winner and its data into data, pulse winner's ack in same cycle, go ISSUE; no req -> stay.
REQ-022 Winner: control if ctrl_req and not (audio_req and ctrl_streak == MAX_CTRL_BURST); else audio if audio_req.
REQ-023 ctrl_streak: saturating counter, +1 on control grant, cleared on audio grant, unchanged otherwise.
REQ-024 ISSUE: cmd = winner code for exactly one cycle, then WAIT_BUSY; cmd = 00 in all other states.
REQ-025 data SHALL hold the captured word from ISSUE until next grant.
REQ-026 WAIT_BUSY: busy=1 -> WAIT_DONE; else count; count reaching BUSY_TIMEOUT -> pulse timeout_err, go IDLE, transaction not counted.
REQ-027 WAIT_DONE: busy=0 -> IDLE and transaction complete; no timeout in this state.
REQ-028 Next grant earliest one cycle after return to IDLE; at most one ack per transaction.
REQ-029 Packet accounting: completed control transaction -> pending +1; completed audio transaction -> audio_cnt +1, wrap at AUDIO_WORDS_PER_PKT to 0 with pending +1.
REQ-030 pending: 4-bit, saturates at 15; increment at saturation sets pend_ovf; simultaneous increment and decrement -> unchanged.
REQ-031 Send scheduler: sendData pulses one cycle when pending > 0, sending = 0, gap_cnt = 0; same cycle pending -1 and gap_cnt loads SEND_GAP.
REQ-032 gap_cnt decrements by 1 per cycle to 0; sendData never pulses on consecutive cycles.
REQ-033 Scheduler SHALL run independently of arbiter FSM; both may act in the same cycle.

Reset
REQ-034 reset SHALL take priority over all activity, including mid-transaction.
REQ-035 On reset: FSM IDLE; cmd 00; data 0; ctrl_ack, audio_ack, sendData, timeout_err 0; pend_ovf 0; ctrl_streak, audio_cnt, pending, gap_cnt, timeout count 0.
REQ-036 A request held through reset SHALL be granted normally after reset deasserts.

Verification
REQ-037 ctrl_req with ctrl_data=16'hA55A, busy rises 2 cycles after cmd, lasts 16 cycles -> ctrl_ack 1 cycle, cmd=01 1 cycle, data=A55A, pending 0->1, sendData 1 cycle with sending=0.
REQ-038 ctrl_req and audio_req held continuously, sender busy 3 cycles each -> grant order C,C,C,C,A,C,C,C,C,A.
REQ-039 7 audio transactions only -> pending stays 0 through 6th, becomes 1 after 7th; audio_cnt back to 0.
REQ-040 busy held 0 after control cmd -> timeout_err pulse 255 cycles after WAIT_BUSY entry, FSM IDLE, pending unchanged.
REQ-041 3 control packets complete within 10 cycles, sending=0 -> sendData pulses spaced exactly 65 cycles apart (SEND_GAP=64), pending 3->0; with sending=1 held, no pulses.
REQ-042 reset asserted during WAIT_DONE with pending=15 and pend_ovf=1 -> next cycle all outputs and counters per REQ-035.
